// File: rtl/decode_pkg.sv
// Shared constants and encodings for the decode stage and its register file.
package decode_pkg;
  localparam int SEL_W    = 3;
  localparam int NUM_REGS = 8;

  localparam logic [4:0]       HALT_OP          = 5'b00000;
  localparam logic [SEL_W-1:0] LINK_REG_DEFAULT = 3'd7;

  typedef enum logic [1:0] {
    DEST_RT   = 2'd0,
    DEST_RS   = 2'd1,
    DEST_RD   = 2'd2,
    DEST_LINK = 2'd3
  } reg_dest_e;

  typedef enum logic [1:0] {
    IMM_SEXT5  = 2'd0,
    IMM_ZEXT5  = 2'd1,
    IMM_SEXT8  = 2'd2,
    IMM_SEXT11 = 2'd3
  } imm_sel_e;
endpackage

// File: rtl/rf_bypass.sv
// 8-entry register file with two read ports, one write port and write-through
// bypass so a same-cycle write is seen by the reads.
module rf_bypass
  import decode_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  rd_sel1,
  input  logic [SEL_W-1:0]  rd_sel2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data
);
  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_sel] <= wr_data;
    end
  end

  assign rd_data1 = (wr_en && wr_sel == rd_sel1) ? wr_data : regs[rd_sel1];
  assign rd_data2 = (wr_en && wr_sel == rd_sel2) ? wr_data : regs[rd_sel2];
endmodule

// File: rtl/decode_stage.sv
// Decode stage: field extraction, immediate extension, register read with
// bypass, pending-write scoreboard for RAW/WAW stalls, registered output.
module decode_stage
  import decode_pkg::*;
#(
  parameter int               DATA_W   = 16,
  parameter logic [SEL_W-1:0] LINK_REG = LINK_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [1:0]        RegDest,
  input  logic              in_regwrite,
  input  logic [1:0]        imm_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        opcode,
  output logic [DATA_W-1:0] reg1data,
  output logic [DATA_W-1:0] reg2data,
  output logic [DATA_W-1:0] imm,
  output logic [SEL_W-1:0]  writeregsel,
  output logic              out_regwrite,
  output logic              out_halt,
  input  logic              wb_en,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              err
);
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A producer holding valid keeps its payload stable until it transfers;
  // the output bundle is held unchanged while out_valid && !out_ready.

  logic [SEL_W-1:0]    rs, rt, dest;
  logic [DATA_W-1:0]   rd1, rd2, imm_ext;
  logic [NUM_REGS-1:0] pending, wb_vec, dest_vec, live, set_vec;
  logic                halted, hazard, accept;

  assign rs = instr[10:8];
  assign rt = instr[7:5];

  always_comb begin
    dest = rt;
    case (RegDest)
      DEST_RT:   dest = instr[7:5];
      DEST_RS:   dest = instr[10:8];
      DEST_RD:   dest = instr[4:2];
      DEST_LINK: dest = LINK_REG;
      default:   dest = instr[7:5];
    endcase
  end

  always_comb begin
    imm_ext = '0;
    case (imm_sel)
      IMM_SEXT5:  imm_ext = {{(DATA_W-5){instr[4]}}, instr[4:0]};
      IMM_ZEXT5:  imm_ext = {{(DATA_W-5){1'b0}}, instr[4:0]};
      IMM_SEXT8:  imm_ext = {{(DATA_W-8){instr[7]}}, instr[7:0]};
      IMM_SEXT11: imm_ext = {{(DATA_W-11){instr[10]}}, instr[10:0]};
      default:    imm_ext = '0;
    endcase
  end

  rf_bypass #(.DATA_W(DATA_W)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rd_sel1  (rs),
    .rd_sel2  (rt),
    .rd_data1 (rd1),
    .rd_data2 (rd2),
    .wr_en    (wb_en),
    .wr_sel   (wb_sel),
    .wr_data  (wb_data)
  );

  // A register whose writeback lands this cycle no longer blocks, which lets
  // a stalled instruction issue in the same cycle as its releasing writeback.
  assign wb_vec   = wb_en ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << wb_sel) : '0;
  assign dest_vec = {{(NUM_REGS-1){1'b0}}, 1'b1} << dest;
  assign live     = pending & ~wb_vec;
  assign hazard   = live[rs] | live[rt] | (in_regwrite & live[dest]);
  assign in_ready = !halted && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign set_vec  = (accept && in_regwrite) ? dest_vec : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      pending <= live | set_vec;
      if (accept && instr[15:11] == HALT_OP) halted <= 1'b1;
      if (wb_en && !pending[wb_sel]) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      opcode       <= '0;
      reg1data     <= '0;
      reg2data     <= '0;
      imm          <= '0;
      writeregsel  <= '0;
      out_regwrite <= 1'b0;
      out_halt     <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      opcode       <= instr[15:11];
      reg1data     <= rd1;
      reg2data     <= rd2;
      imm          <= imm_ext;
      writeregsel  <= dest;
      out_regwrite <= in_regwrite;
      out_halt     <= (instr[15:11] == HALT_OP);
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end
endmodule
